// File: rtl/alu_sequencer_pkg.sv
// Shared opcode encodings and FSM state type for the ALU sequencer and its
// combinational core.
package alu_sequencer_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_LT  = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_EXEC     = 2'd1;
  localparam state_t ST_MOD_LOOP = 2'd2;
  localparam state_t ST_DONE     = 2'd3;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response bundle between a requester (master) and the ALU sequencer
// (slave).
interface alu_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [2:0]       Alu_Op;
  logic [WIDTH-1:0] bit1;
  logic [WIDTH-1:0] bit2;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] res;
  logic             cout;
  logic             div_zero;

  modport master (
    output start, Alu_Op, bit1, bit2,
    input  ready, done, res, cout, div_zero
  );

  modport slave (
    input  start, Alu_Op, bit1, bit2,
    output ready, done, res, cout, div_zero
  );

endinterface

// File: rtl/alu_core.sv
// Single-cycle ALU operations; MOD is handled by the sequencer and yields
// zeros here.
module alu_core
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             cout
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    res  = '0;
    cout = 1'b0;
    case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_ADD: begin
        res  = sum[WIDTH-1:0];
        cout = sum[WIDTH];
      end
      OP_XOR: res = a ^ b;
      OP_NOR: res = ~(a | b);
      OP_LT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SUB: begin
        res  = a - b;
        cout = (a < b);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Request sequencer: accepts one operation at a time, runs single-cycle ops
// through alu_core and MOD by repeated subtraction, then pulses done.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           CLK,
  input  logic           reset,
  alu_sequencer_if.slave bus
);

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] res_q;
  logic             cout_q;
  logic             div_zero_q;
  logic [WIDTH-1:0] core_res;
  logic             core_cout;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .res  (core_res),
    .cout (core_cout)
  );

  assign bus.ready    = (state == ST_IDLE);
  assign bus.done     = (state == ST_DONE);
  assign bus.res      = res_q;
  assign bus.cout     = cout_q;
  assign bus.div_zero = div_zero_q;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= OP_AND;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      res_q      <= '0;
      cout_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            op_q  <= bus.Alu_Op;
            a_q   <= bus.bit1;
            b_q   <= bus.bit2;
            rem_q <= bus.bit1;
            state <= (bus.Alu_Op == OP_MOD) ? ST_MOD_LOOP : ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q      <= core_res;
          cout_q     <= core_cout;
          div_zero_q <= 1'b0;
          state      <= ST_DONE;
        end
        ST_MOD_LOOP: begin
          // A zero divisor would never leave the loop; flag it on the first pass.
          if (b_q == '0) begin
            res_q      <= '0;
            cout_q     <= 1'b0;
            div_zero_q <= 1'b1;
            state      <= ST_DONE;
          end else if (rem_q >= b_q) begin
            rem_q <= rem_q - b_q;
          end else begin
            res_q      <= rem_q;
            cout_q     <= 1'b0;
            div_zero_q <= 1'b0;
            state      <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed, table-driven bench for alu_sequencer with hand-written sequences
// for held start and mid-operation reset.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic CLK;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] prev_res;

  alu_sequencer_if #(.WIDTH(32)) bus ();

  alu_sequencer #(.WIDTH(32)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e_res;
    logic        e_cout;
    logic        e_dz;
    int          e_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int   guard;
    int   lat;
    int   rlow;
    logic seen;
    guard = 0;
    @(negedge CLK);
    while (!bus.ready && guard < 500) begin
      @(negedge CLK);
      guard++;
    end
    check({v.name, "/ready_before"}, {31'd0, bus.ready}, 32'd1);
    bus.start  = 1'b1;
    bus.Alu_Op = v.op;
    bus.bit1   = v.a;
    bus.bit2   = v.b;
    @(posedge CLK);
    @(negedge CLK);
    bus.start = 1'b0;
    check({v.name, "/res_hold_on_accept"}, bus.res, prev_res);
    lat  = 1;
    rlow = 0;
    seen = 1'b0;
    while (lat < 600) begin
      if (!bus.ready) rlow++;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
      lat++;
    end
    check({v.name, "/done_seen"}, {31'd0, seen}, 32'd1);
    check({v.name, "/latency"}, lat, v.e_lat);
    check({v.name, "/ready_low_cycles"}, rlow, v.e_lat);
    check({v.name, "/res"}, bus.res, v.e_res);
    check({v.name, "/cout"}, {31'd0, bus.cout}, {31'd0, v.e_cout});
    check({v.name, "/div_zero"}, {31'd0, bus.div_zero}, {31'd0, v.e_dz});
    @(negedge CLK);
    check({v.name, "/done_one_cycle"}, {31'd0, bus.done}, 32'd0);
    check({v.name, "/ready_after"}, {31'd0, bus.ready}, 32'd1);
    prev_res = v.e_res;
  endtask

  vec_t vecs[18];

  initial begin
    int   lat;
    int   pulses;
    int   guard;
    logic rdy_dropped;

    total    = 0;
    bad      = 0;
    prev_res = '0;

    vecs[0]  = '{"add_carry",   OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 2};
    vecs[1]  = '{"sub_borrow",  OP_SUB, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b1, 1'b0, 2};
    vecs[2]  = '{"lt_neg",      OP_LT,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1'b0, 2};
    vecs[3]  = '{"mod_17_5",    OP_MOD, 32'd17,        32'd5,         32'd2,         1'b0, 1'b0, 5};
    vecs[4]  = '{"mod_3_7",     OP_MOD, 32'd3,         32'd7,         32'd3,         1'b0, 1'b0, 2};
    vecs[5]  = '{"mod_9_0",     OP_MOD, 32'd9,         32'd0,         32'd0,         1'b0, 1'b1, 2};
    vecs[6]  = '{"and",         OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 2};
    vecs[7]  = '{"or",          OP_OR,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 2};
    vecs[8]  = '{"xor",         OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 2};
    vecs[9]  = '{"nor",         OP_NOR, 32'h0F0F_0F0F, 32'hF0F0_0000, 32'h0000_F0F0, 1'b0, 1'b0, 2};
    vecs[10] = '{"add_nocarry", OP_ADD, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0, 1'b0, 2};
    vecs[11] = '{"sub_pos",     OP_SUB, 32'd7,         32'd5,         32'd2,         1'b0, 1'b0, 2};
    vecs[12] = '{"lt_false",    OP_LT,  32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0, 2};
    vecs[13] = '{"lt_min_max",  OP_LT,  32'h8000_0000, 32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0, 2};
    vecs[14] = '{"mod_20_5",    OP_MOD, 32'd20,        32'd5,         32'd0,         1'b0, 1'b0, 6};
    vecs[15] = '{"mod_5_5",     OP_MOD, 32'd5,         32'd5,         32'd0,         1'b0, 1'b0, 3};
    vecs[16] = '{"sub_zero",    OP_SUB, 32'd0,         32'd0,         32'd0,         1'b0, 1'b0, 2};
    vecs[17] = '{"mod_0_0",     OP_MOD, 32'd0,         32'd0,         32'd0,         1'b0, 1'b1, 2};

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.Alu_Op = OP_AND;
    bus.bit1   = '0;
    bus.bit2   = '0;
    repeat (3) @(negedge CLK);
    check("reset/ready", {31'd0, bus.ready}, 32'd1);
    check("reset/done", {31'd0, bus.done}, 32'd0);
    check("reset/res", bus.res, 32'd0);
    check("reset/cout", {31'd0, bus.cout}, 32'd0);
    check("reset/div_zero", {31'd0, bus.div_zero}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) run_op(vecs[i]);

    // start held high through a long MOD: later requests must be dropped.
    @(negedge CLK);
    bus.start  = 1'b1;
    bus.Alu_Op = OP_MOD;
    bus.bit1   = 32'd100;
    bus.bit2   = 32'd1;
    @(posedge CLK);
    @(negedge CLK);
    bus.Alu_Op = OP_ADD;
    bus.bit1   = 32'd1;
    bus.bit2   = 32'd1;
    lat         = 1;
    pulses      = 0;
    rdy_dropped = 1'b1;
    while (lat < 300) begin
      if (bus.ready) rdy_dropped = 1'b0;
      if (bus.done) begin
        pulses++;
        break;
      end
      @(negedge CLK);
      lat++;
    end
    check("held/done_pulses", pulses, 32'd1);
    check("held/latency", lat, 32'd102);
    check("held/ready_stayed_low", {31'd0, rdy_dropped}, 32'd1);
    check("held/res", bus.res, 32'd0);
    check("held/div_zero", {31'd0, bus.div_zero}, 32'd0);
    @(negedge CLK);
    check("held/idle_after_done", {31'd0, bus.ready}, 32'd1);
    check("held/no_second_done", {31'd0, bus.done}, 32'd0);
    @(negedge CLK);
    check("held/next_accepted", {31'd0, bus.ready}, 32'd0);
    bus.start = 1'b0;
    guard = 0;
    while (!bus.done && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    check("held/next_done", {31'd0, bus.done}, 32'd1);
    check("held/next_res", bus.res, 32'd2);
    prev_res = 32'd2;

    // Reset in the middle of MOD 1000 mod 3.
    @(negedge CLK);
    @(negedge CLK);
    bus.start  = 1'b1;
    bus.Alu_Op = OP_MOD;
    bus.bit1   = 32'd1000;
    bus.bit2   = 32'd3;
    @(posedge CLK);
    @(negedge CLK);
    bus.start = 1'b0;
    repeat (20) @(negedge CLK);
    check("midrst/busy_before", {31'd0, bus.ready}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("midrst/ready", {31'd0, bus.ready}, 32'd1);
    check("midrst/done", {31'd0, bus.done}, 32'd0);
    check("midrst/res", bus.res, 32'd0);
    check("midrst/cout", {31'd0, bus.cout}, 32'd0);
    check("midrst/div_zero", {31'd0, bus.div_zero}, 32'd0);
    @(negedge CLK);
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (bus.done) pulses++;
    end
    check("midrst/no_done", pulses, 32'd0);
    check("midrst/idle", {31'd0, bus.ready}, 32'd1);
    prev_res = 32'd0;
    run_op('{"post_reset_or", OP_OR, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 2});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request strobe, sampled on a CLK edge.
REQ-005 Alu_Op  input  3  operation code, sampled with start.
REQ-006 bit1  input  WIDTH  operand A, sampled with start.
REQ-007 bit2  input  WIDTH  operand B, sampled with start.
REQ-008 ready  output  1  high when a new request is accepted.
REQ-009 done  output  1  one-cycle pulse when res/cout/div_zero are valid.
REQ-010 res  output  WIDTH  registered result.
REQ-011 cout  output  1  registered carry (ADD) / borrow (SUB), else 0.
REQ-012 div_zero  output  1  registered flag: MOD requested with bit2 == 0.

Function
REQ-013 Opcodes SHALL be: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 LT, 110 SUB, 111 MOD.
REQ-014 FSM states SHALL be IDLE, EXEC, MOD_LOOP, DONE; ready SHALL equal (state == IDLE).
REQ-015 In IDLE with start=1, the block SHALL latch Alu_Op, bit1, bit2 and go to MOD_LOOP if Alu_Op=111, else EXEC; start=0 keeps IDLE.
REQ-016 start outside IDLE SHALL be ignored without side effects; no queuing.
REQ-017 EXEC SHALL compute the latched op in one cycle, register res/cout, clear div_zero, and go to DONE.
REQ-018 ADD/SUB SHALL be modulo 2^WIDTH; cout = carry-out for ADD, borrow (A < B unsigned) for SUB, 0 for other ops.
REQ-019 LT SHALL be signed two's-complement: res = 1 if A < B else 0.
REQ-020 MOD SHALL be unsigned A mod B via repeated subtraction, one subtraction per cycle in MOD_LOOP on an internal remainder register initialised to A.
REQ-021 MOD_LOOP: remainder >= B -> remainder <= remainder - B, stay; else res <= remainder, cout <= 0, go to DONE.
REQ-022 MOD with B == 0 SHALL spend one MOD_LOOP cycle, then res <= 0, div_zero <= 1, go to DONE.
REQ-023 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-024 Latency: done high N+2 cycles after the accepting edge, N = number of subtractions (N = 0 for non-MOD and for B == 0).
REQ-025 res, cout, div_zero SHALL hold their values from done until the next completion; they SHALL NOT change on accept.

Reset
REQ-026 reset=1 SHALL immediately force state IDLE; res=0, cout=0, div_zero=0, done=0; ready=1.
REQ-027 Reset mid-operation SHALL abort it with no done pulse; the first post-reset request behaves as from power-up.

Structure
REQ-028 A shared package SHALL hold the opcode constants and the FSM state typedef.
REQ-029 Single-cycle ops (all except MOD) SHALL sit in one combinational sub-module, alu_core; the FSM, remainder register and MOD subtractor stay in alu_sequencer.

Verification
REQ-030 Reset then ADD 0xFFFFFFFF + 0x00000001 -> done 2 cycles after accept, res=0x00000000, cout=1.
REQ-031 SUB 5 - 7 -> res=0xFFFFFFFE, cout=1; LT 0xFFFFFFFF vs 1 -> res=1.
REQ-032 MOD 17 mod 5 -> ready low 5 cycles, done 5 cycles after accept, res=2, div_zero=0; MOD 3 mod 7 -> res=3, done at +2.
REQ-033 MOD 9 mod 0 -> done at +2, res=0, div_zero=1; following AND 0xF0F0 & 0xFF00 -> res=0xF000, div_zero=0.
REQ-034 start held high through a MOD 100 mod 1 run -> only one done pulse, other requests dropped, res=0; next request accepted the cycle after DONE.
REQ-035 reset asserted mid-MOD 1000 mod 3 -> state IDLE, outputs zero, no done; subsequent OR 0x1 | 0x2 -> res=0x3.
